// File: rtl/sha256_core_arbiter.sv
// Round-robin arbiter sharing one SHA-256 compression core between NUM_REQ requesters.
// Optional core watchdog with err_timeout output: define SHA256_ARB_TIMEOUT_EN.
module sha256_core_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*512-1:0] req_block,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [255:0]           rsp_digest,
    output logic                   core_start,
    output logic [511:0]           core_block,
    output logic [255:0]           core_chain_in,
    input  logic                   core_done,
    input  logic [255:0]           core_hash,
    output logic                   busy,
    output logic [ID_W-1:0]        grant_id
`ifdef SHA256_ARB_TIMEOUT_EN
    ,
    output logic                   err_timeout
`endif
);

    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    typedef enum logic [2:0] {IDLE, ISSUE, START, WAIT, RESP, DRAIN} state_t;

    state_t                       state;
    logic [ID_W-1:0]              rr_ptr;
    logic [ID_W-1:0]              owner;
    logic [255:0]                 chain;
    logic                         last_q;
    logic [ID_W-1:0]              arb_pick;
    logic [NUM_REQ-1:0][511:0]    blk_v;

`ifdef SHA256_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            aborted;
`endif

    assign blk_v = req_block;

    // First requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
    function automatic logic [ID_W-1:0] pick(input logic [NUM_REQ-1:0] v, input logic [ID_W-1:0] ptr);
        logic [ID_W-1:0] r;
        logic            found;
        int              idx;
        r     = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && v[idx]) begin
                r     = ID_W'(idx);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] o);
        logic [NUM_REQ-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_REQ; i++) r[i] = (o == ID_W'(i));
        return r;
    endfunction

    assign arb_pick      = pick(req_valid, rr_ptr);
    assign core_chain_in = chain;
    assign grant_id      = owner;
    assign rsp_id        = rsp_valid ? owner : '0;
    assign rsp_digest    = rsp_valid ? chain : '0;

    // Outputs are registered alongside each transition so they always match the state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            chain      <= IV;
            last_q     <= 1'b0;
            core_block <= '0;
            req_ready  <= '0;
            core_start <= 1'b0;
            rsp_valid  <= 1'b0;
            busy       <= 1'b0;
`ifdef SHA256_ARB_TIMEOUT_EN
            wd_cnt      <= '0;
            aborted     <= 1'b0;
            err_timeout <= 1'b0;
`endif
        end else begin
            core_start <= 1'b0;
            case (state)
                IDLE: begin
                    chain <= IV;
`ifdef SHA256_ARB_TIMEOUT_EN
                    aborted <= 1'b0;
`endif
                    if (|req_valid) begin
                        owner     <= arb_pick;
                        req_ready <= onehot(arb_pick);
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (req_valid[owner]) begin
                        core_block <= blk_v[owner];
                        last_q     <= req_last[owner];
                        req_ready  <= '0;
                        core_start <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
`ifdef SHA256_ARB_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (core_done) begin
                        chain <= core_hash;
                        if (last_q) begin
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            req_ready <= onehot(owner);
                            state     <= ISSUE;
                        end
                    end
`ifdef SHA256_ARB_TIMEOUT_EN
                    else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        chain       <= '0;
                        aborted     <= 1'b1;
                        err_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rr_ptr    <= (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                        rsp_valid <= 1'b0;
`ifdef SHA256_ARB_TIMEOUT_EN
                        if (aborted && !last_q) begin
                            // Swallow the rest of the aborted message before re-arbitrating.
                            req_ready <= onehot(owner);
                            state     <= DRAIN;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
`else
                        busy  <= 1'b0;
                        state <= IDLE;
`endif
                    end
                end
`ifdef SHA256_ARB_TIMEOUT_EN
                DRAIN: begin
                    if (req_valid[owner] && req_last[owner]) begin
                        req_ready <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
`endif
                default: begin
                    req_ready <= '0;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_core_arbiter.sv
// Directed bench for sha256_core_arbiter; the bench plays the compression core with fixed hash replies.
module tb_sha256_core_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;
`ifdef SHA256_ARB_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 255;
`endif
    localparam int CORE_LAT = 3;

    localparam logic [255:0] IV    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_H = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] MID   = 256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a;
    localparam logic [255:0] H2    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [511:0] ABC   = {32'h61626380, 416'h0, 64'h18};
    localparam logic [511:0] B1    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] B2    = {448'h0, 64'h1c0};

    logic                   clk;
    logic                   reset_n;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*512-1:0] req_block;
    logic [NUM_REQ-1:0]     req_last;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [255:0]           rsp_digest;
    logic                   core_start;
    logic [511:0]           core_block;
    logic [255:0]           core_chain_in;
    logic                   core_done;
    logic [255:0]           core_hash;
    logic                   busy;
    logic [ID_W-1:0]        grant_id;
`ifdef SHA256_ARB_TIMEOUT_EN
    logic                   err_timeout;
`endif

    sha256_core_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_block(req_block), .req_last(req_last),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_digest(rsp_digest),
        .core_start(core_start), .core_block(core_block), .core_chain_in(core_chain_in),
        .core_done(core_done), .core_hash(core_hash), .busy(busy), .grant_id(grant_id)
`ifdef SHA256_ARB_TIMEOUT_EN
        , .err_timeout(err_timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: replies CORE_LAT cycles after start with the hash staged in next_hash.
    logic         core_auto = 1'b1;
    logic [255:0] next_hash = '0;
    logic         man_done  = 1'b0;
    logic [255:0] man_hash  = '0;
    logic         auto_done = 1'b0;
    logic [255:0] auto_hash = '0;
    logic [255:0] pend_hash = '0;
    int           pend      = 0;

    always @(negedge clk) begin
        auto_done = 1'b0;
        if (pend == 1) begin
            auto_done = 1'b1;
            auto_hash = pend_hash;
        end
        if (pend > 0) pend--;
        if (core_start && core_auto) begin
            pend      = CORE_LAT;
            pend_hash = next_hash;
        end
    end

    assign core_done = auto_done | man_done;
    assign core_hash = man_done ? man_hash : auto_hash;

    int           starts  = 0;
    int           rsps    = 0;
    int           bad_rdy = 0;
    int           rdy1    = 0;
    logic [255:0] chain_log [0:63];
    logic [511:0] blk_log   [0:63];

    always @(negedge clk) begin
        if (core_start) begin
            chain_log[starts % 64] = core_chain_in;
            blk_log[starts % 64]   = core_block;
            starts++;
        end
        if (rsp_valid) rsps++;
        if ((req_ready & ~(2'b01 << grant_id)) != '0) bad_rdy++;
        if (req_ready[1]) rdy1++;
    end

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_block(input int i, input logic [511:0] blk, input logic last);
        logic got;
        got = 1'b0;
        req_block[i*512 +: 512] = blk;
        req_last[i]             = last;
        req_valid[i]            = 1'b1;
        for (int c = 0; c < 300 && !got; c++) begin
            if (req_ready[i]) got = 1'b1;
            tick(1);
        end
        req_valid[i] = 1'b0;
        chk("handshake", got, 1'b1);
    endtask

    task automatic wait_rsp();
        for (int c = 0; c < 300 && !rsp_valid; c++) tick(1);
        chk("rsp_seen", rsp_valid, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0, r0, n, c;
        int ids [6];
        reset_n   = 1'b0;
        req_valid = '0;
        req_block = '0;
        req_last  = '0;
        rsp_ready = 1'b1;
        tick(3);

        chk("rst_busy", busy, 1'b0);
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_core_start", core_start, 1'b0);
        chk("rst_chain_in", core_chain_in, IV);
        chk("rst_core_block", core_block, 512'h0);
        chk("rst_grant_id", grant_id, 1'b0);
        chk("rst_rsp_id", rsp_id, 1'b0);
        chk("rst_rsp_digest", rsp_digest, 256'h0);
        reset_n = 1'b1;
        tick(1);

        // Single-block "abc" on requester 0.
        s0 = starts;
        next_hash          = ABC_H;
        req_block[511:0]   = ABC;
        req_last           = 2'b01;
        req_valid          = 2'b01;
        tick(1);
        chk("abc_ready", req_ready, 2'b01);
        chk("abc_busy", busy, 1'b1);
        tick(1);
        req_valid = 2'b00;
        chk("abc_start", core_start, 1'b1);
        chk("abc_block", core_block, ABC);
        chk("abc_chain_in", core_chain_in, IV);
        chk("abc_ready_off", req_ready, 2'b00);
        tick(1);
        chk("abc_start_pulse", core_start, 1'b0);
        wait_rsp();
        chk("abc_rsp_id", rsp_id, 1'b0);
        chk("abc_digest", rsp_digest, ABC_H);
        chk("abc_nstarts", starts - s0, 1);
        tick(1);
        chk("abc_rsp_drop", rsp_valid, 1'b0);
        chk("abc_idle", busy, 1'b0);

        // Two-block message on requester 1; chaining value carried between blocks.
        s0 = starts;
        next_hash = MID;
        send_block(1, B1, 1'b0);
        tick(1);
        next_hash = H2;
        send_block(1, B2, 1'b1);
        wait_rsp();
        chk("two_nstarts", starts - s0, 2);
        chk("two_chain0", chain_log[s0 % 64], IV);
        chk("two_chain1", chain_log[(s0 + 1) % 64], MID);
        chk("two_blk0", blk_log[s0 % 64], B1);
        chk("two_blk1", blk_log[(s0 + 1) % 64], B2);
        chk("two_rsp_id", rsp_id, 1'b1);
        chk("two_digest", rsp_digest, H2);
        tick(1);

        // Both requesters always valid: grants alternate.
        next_hash  = ABC_H;
        req_block  = {ABC, ABC};
        req_last   = 2'b11;
        req_valid  = 2'b11;
        n = 0;
        for (int k = 0; k < 400 && n < 6; k++) begin
            tick(1);
            if (rsp_valid) begin
                ids[n] = int'(rsp_id);
                n++;
                if (n == 6) req_valid = 2'b00;
            end
        end
        chk("rr_count", n, 6);
        for (int k = 0; k < 6; k++) chk($sformatf("rr_id%0d", k), ids[k], k % 2);
        chk("rr_nonowner_ready", bad_rdy, 0);
        tick(3);
        chk("rr_idle", busy, 1'b0);

        // Requester 0 stalls mid-message; requester 1 must wait for 0's digest.
        r0 = rdy1;
        req_block[1023:512] = ABC;
        req_last[1]         = 1'b1;
        req_valid[1]        = 1'b1;
        next_hash = MID;
        send_block(0, B1, 1'b0);
        tick(20);
        chk("stall_grant", grant_id, 1'b0);
        next_hash = H2;
        send_block(0, B2, 1'b1);
        wait_rsp();
        chk("stall_rsp_id", rsp_id, 1'b0);
        chk("stall_digest", rsp_digest, H2);
        chk("stall_ready1", rdy1 - r0, 0);
        next_hash = ABC_H;
        send_block(1, ABC, 1'b1);
        wait_rsp();
        chk("stall_rsp_id1", rsp_id, 1'b1);
        chk("stall_digest1", rsp_digest, ABC_H);
        tick(2);

        // Back-pressure on the response: outputs hold, no new core activity.
        rsp_ready = 1'b0;
        next_hash = H2;
        s0 = starts;
        send_block(0, ABC, 1'b1);
        wait_rsp();
        req_block[1023:512] = ABC;
        req_last[1]         = 1'b1;
        req_valid[1]        = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            chk("hold_valid", rsp_valid, 1'b1);
            chk("hold_id", rsp_id, 1'b0);
            chk("hold_digest", rsp_digest, H2);
        end
        chk("hold_nstarts", starts - s0, 1);
        chk("hold_ready1", req_ready, 2'b00);
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        tick(2);
        chk("hold_idle", busy, 1'b0);

        // Reset during WAIT aborts the message; a late core_done is ignored.
        core_auto = 1'b0;
        send_block(1, ABC, 1'b1);
        tick(1);
        chk("mid_busy", busy, 1'b1);
        reset_n = 1'b0;
        tick(1);
        chk("mid_req_ready", req_ready, 2'b00);
        chk("mid_busy_off", busy, 1'b0);
        chk("mid_rsp_valid", rsp_valid, 1'b0);
        chk("mid_core_start", core_start, 1'b0);
        chk("mid_core_block", core_block, 512'h0);
        chk("mid_chain_in", core_chain_in, IV);
        chk("mid_grant", grant_id, 1'b0);
        chk("mid_digest", rsp_digest, 256'h0);
        reset_n = 1'b1;
        tick(1);
        r0 = rsps;
        man_hash = H2;
        man_done = 1'b1;
        tick(1);
        man_done = 1'b0;
        tick(4);
        chk("late_done_rsp", rsps - r0, 0);
        chk("late_done_busy", busy, 1'b0);

`ifdef SHA256_ARB_TIMEOUT_EN
        // Core never answers: watchdog aborts, remaining block is drained.
        send_block(0, B1, 1'b0);
        c = 0;
        while (!rsp_valid && c < 100) begin
            tick(1);
            c++;
        end
        chk("to_latency", c, 17);
        chk("to_digest", rsp_digest, 256'h0);
        chk("to_err", err_timeout, 1'b1);
        chk("to_rsp_id", rsp_id, 1'b0);
        s0 = starts;
        tick(1);
        send_block(0, B2, 1'b1);
        tick(1);
        chk("to_drain_nstarts", starts - s0, 0);
        chk("to_drain_idle", busy, 1'b0);
        chk("to_err_sticky", err_timeout, 1'b1);
`else
        c = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/sha256_core_arbiter.md
Name: sha256_core_arbiter

Overview:
- Shares one SHA-256 compression core between NUM_REQ requesters.
- Each requester submits a message as a sequence of pre-padded 512-bit blocks over valid/ready. The arbiter grants requesters round-robin and holds the grant for a whole message.
- Sequences the core with start/done, carries the 256-bit chaining value between blocks, and returns the final digest tagged with the requester ID.
- Sits between host-side message sources and the compression core.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ) (min 1), requester ID width.
- TIMEOUT_CYCLES, 255, core watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester block valid.
- req_ready  out  NUM_REQ  per-requester block accept.
- req_block  in  NUM_REQ*512  requester i block at [i*512 +: 512], word 0 in MSBs.
- req_last  in  NUM_REQ  block is the final block of its message.
- rsp_valid  out  1  digest available.
- rsp_ready  in  1  digest consumer ready.
- rsp_id  out  ID_W  owner of the digest.
- rsp_digest  out  256  final hash {H0..H7}.
- core_start  out  1  one-cycle start pulse to the core.
- core_block  out  512  block presented to the core.
- core_chain_in  out  256  chaining value H_in.
- core_done  in  1  one-cycle done pulse from the core.
- core_hash  in  256  H_in + compression(block), valid while core_done=1.
- busy  out  1  state != IDLE.
- grant_id  out  ID_W  current owner.

Behaviour:
- Reset: state=IDLE, rr_ptr=0, owner=0, chain=IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19). All outputs 0 except core_chain_in=IV.
- Reset mid-operation aborts the message. No response is produced. Any later core_done is ignored because the arbiter is in IDLE.
- IDLE: chain<=IV.
  - If any req_valid: owner <= first set bit searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ. Go to ISSUE.
  - Arbitration costs one cycle; no block is accepted in IDLE.
- ISSUE: req_ready[owner]=1, all other req_ready bits 0. This is a Moore output.
  - On req_valid[owner]: latch block into core_block and req_last into last_q. Go to START.
  - If the owner deasserts valid, wait indefinitely. The grant stays locked and other requesters are not served.
- START: core_start=1 for exactly one cycle. core_block and core_chain_in stay stable from START until leaving WAIT. Go to WAIT.
- WAIT: core_done outside WAIT is ignored. On core_done: chain<=core_hash.
  - If last_q=1, go to RESP.
  - Otherwise go to ISSUE; the next block can be accepted in the cycle after core_done.
- RESP: rsp_valid=1, rsp_id=owner, rsp_digest=chain. All three are held stable until rsp_ready.
  - On rsp_ready: rr_ptr <= (owner+1) wrapping at NUM_REQ-1→0. Go to IDLE.
  - A new request pending at the same time is arbitrated in IDLE on the following cycle.
- Latency: block handshake → core_start on the next cycle. core_done of the last block → rsp_valid on the next cycle.
- Fairness: after requester i is served, i has the lowest priority. With all requesters always valid, grants rotate 0,1,...,NUM_REQ-1,0.
- NUM_REQ=1: rr_ptr stays 0 and the arbiter degenerates to a block sequencer.
- Arithmetic: no additions are done in this block. core_hash is already feed-forward summed.

Optional Feature:
- Macro: SHA256_ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs in WAIT and clears on entering WAIT.
  - If TIMEOUT_CYCLES cycles pass without core_done, the message is aborted.
  - RESP is entered with rsp_digest=0 and a sticky output err_timeout=1 (extra 1-bit port). err_timeout clears only on reset.
  - Remaining blocks of the aborted message are still accepted and discarded until the block with req_last, then the arbiter returns to IDLE.
- Undefined: no counter and no err_timeout port; WAIT waits forever.

Test Plan:
- Single block "abc" (616263 80 00… length 0x18) on requester 0, last=1 → one core_start; rsp_id=0; rsp_digest=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" on requester 1 → two core_start pulses; the second core_chain_in equals the first core_hash; rsp_digest=248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Both requesters always valid with single-block messages, 6 messages → rsp_id sequence 0,1,0,1,0,1; req_ready never asserted for the non-owner.
- Requester 0 stalls valid for 20 cycles between its blocks while requester 1 is valid → req_ready[1] stays 0 throughout; requester 1 is served after the digest for 0.
- rsp_ready held low for 10 cycles → rsp_valid, rsp_id and rsp_digest stay stable; no core_start occurs. Then reset_n=0 during WAIT → all outputs 0 next cycle, and a late core_done produces no response.
- With SHA256_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, core never responds → rsp_valid 17 cycles after core_start with digest 0 and err_timeout=1.
